// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the fetch FSM encoding, default reset PC and step, and the buffered entry layout.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StDrop
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  // Entry layout for the default widths; PC occupies the upper bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush, occupancy count and same-cycle push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FULL_CNT) || do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one sequential read at a time and
// buffers PC-tagged instructions for decode; redirects flush buffered and in-flight fetches.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy
);

  localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, req_pc_q;
  logic              req_valid_q;
  logic              req_fire, push, pop;
  logic [CNT_W-1:0]  fifo_count, cnt_next;
  entry_t            push_entry, head_entry;

  always_comb begin
    req_fire        = req_valid_q && mem_req_ready;
    push            = (state_q == StWait) && mem_rsp_valid && !redirect_valid;
    pop             = inst_valid && inst_ready;
    push_entry.pc   = req_pc_q;
    push_entry.data = mem_rsp_data;
    // A push always fits: space was checked when its request was issued.
    cnt_next = redirect_valid ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);

    state_d = state_q;
    unique case (state_q)
      StReq:   if (req_fire) state_d = redirect_valid ? StDrop : StWait;
      StWait: begin
        if (mem_rsp_valid)       state_d = StReq;
        else if (redirect_valid) state_d = StDrop;
      end
      StDrop:  if (mem_rsp_valid) state_d = StReq;
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StReq;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == StReq) && (cnt_next < DEPTH_CNT);
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
      end else if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + ADDR_W'(PC_STEP);
      end
      if (req_fire) begin
        req_pc_q <= fetch_pc_q;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = fetch_pc_q;
  assign inst_valid    = (fifo_count != '0);
  assign inst_pc       = head_entry.pc;
  assign inst_data     = head_entry.data;
  assign busy          = (state_q != StReq);

  // Memory must never answer when no request is owed.
  rsp_in_req: assert property (@(posedge clk) disable iff (reset)
    !(mem_rsp_valid && (state_q == StReq)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomised and directed bench for inst_fetch_unit against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RESET_PC),
    .PC_STEP  (4),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: decode-visible queue, next fetch address, one owed response.
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          pend, pend_sq, started;
  logic [31:0] pend_pc;
  int unsigned pend_wait, lat_lo, lat_hi;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected condition reached", tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = RESET_PC;
    pend    = 1'b0;
    pend_sq = 1'b0;
    started = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_inst_valid", 32'(inst_valid), 32'(0));
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_mem_req_addr", mem_req_addr, RESET_PC);
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit mrdy, input bit irdy);
    bit   rsp, exp_req, fire, pop;
    ent_t e;
    rsp            = pend && (pend_wait == 0);
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_req_ready  = mrdy;
    inst_ready     = irdy;
    mem_rsp_valid  = rsp;
    mem_rsp_data   = rsp ? memfn(pend_pc) : $urandom();
    #1;
    check("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("inst_pc", inst_pc, q[0].pc);
      check("inst_data", inst_data, q[0].data);
    end
    exp_req = started && !pend && (q.size() < DEPTH);
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
    if (exp_req) check("mem_req_addr", mem_req_addr, m_pc);
    check("busy", 32'(busy), 32'(pend));

    fire = exp_req && mrdy;
    pop  = (q.size() != 0) && irdy;
    if (redir) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (rsp && !pend_sq) begin
        e.pc   = pend_pc;
        e.data = memfn(pend_pc);
        q.push_back(e);
      end
    end
    if (rsp) begin
      pend = 1'b0;
    end else if (pend) begin
      if (redir) pend_sq = 1'b1;
      if (pend_wait > 0) pend_wait--;
    end
    if (fire) begin
      pend      = 1'b1;
      pend_sq   = redir;
      pend_pc   = m_pc;
      pend_wait = lat_lo + $urandom_range(lat_hi - lat_lo);
    end
    if (redir) m_pc = rpc;
    else if (fire) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned n, input bit mrdy, input bit irdy);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 32'h0, mrdy, irdy);
  endtask

  initial begin
    bit found;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    inst_ready     = 1'b0;
    lat_lo         = 0;
    lat_hi         = 0;
    model_reset();
    #1 reset = 1'b1;
    #11;
    check_reset_outputs();
    @(negedge clk) reset = 1'b0;
    #1 check("post_rst_req_valid", 32'(mem_req_valid), 32'(0));
    @(posedge clk);
    #1 started = 1'b1;

    // Sequential fetch at full rate, latency 1.
    run(8, 1'b1, 1'b1);
    // Back-pressure from decode, then release.
    run(10, 1'b1, 1'b0);
    check("full_head_pc", inst_pc, q[0].pc);
    run(6, 1'b1, 1'b1);
    // Memory stalls a pending request.
    run(5, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);

    // Redirect while waiting on a response.
    lat_lo = 2;
    lat_hi = 2;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && pend_wait > 0 && !pend_sq) begin
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        found = 1'b1;
      end else begin
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
      end
    end
    if (!found) timeout("redirect_in_wait");
    run(10, 1'b1, 1'b1);

    // Redirect in the same cycle as a push and a pop.
    lat_lo = 0;
    lat_hi = 0;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && pend_wait == 0 && !pend_sq && q.size() != 0) begin
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        found = 1'b1;
      end else begin
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
    end
    if (!found) timeout("redirect_push_pop");
    run(8, 1'b1, 1'b1);

    // Address wrap.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    run(8, 1'b1, 1'b1);

    // Asynchronous reset while a response is owed.
    lat_lo = 3;
    lat_hi = 3;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend) found = 1'b1;
      else cycle(1'b0, 32'h0, 1'b1, 1'b1);
    end
    if (!found) timeout("reset_in_wait");
    @(negedge clk);
    mem_rsp_valid  = 1'b0;
    redirect_valid = 1'b0;
    reset          = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 started = 1'b1;
    lat_lo = 0;
    lat_hi = 0;
    run(6, 1'b1, 1'b1);

    // Random traffic.
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      cycle($urandom_range(19) == 0, rpc, $urandom_range(3) != 0, $urandom_range(3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
